// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state (IDLE/EXEC/WB) controller that issues one 16-bit
// instruction at a time to an external combinational 8-bit ALU, keeps a 4x8
// register file and retires results with Z/N/V flags and a one-cycle done.
module alu_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        alu_add_sub,
  output logic        alu_set_low,
  output logic        alu_set_high,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  output logic        done,
  output logic [7:0]  result,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_SETLO = 3'd2,
    OP_SETHI = 3'd3,
    OP_LDI   = 3'd4,
    OP_ADDI  = 3'd5,
    OP_SUBI  = 3'd6,
    OP_NOP   = 3'd7
  } op_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  res_q, res_d;
  logic [7:0]  rf_q [4];
  logic [7:0]  result_q;
  logic        z_q, n_q, v_q;
  logic        done_q;

  // Fields of the captured instruction; bit 8 carries nothing.
  op_e        op;
  logic [1:0] rd, rs;
  logic [7:0] imm;
  logic       unused_ir_bit;

  assign op            = op_e'(ir_q[15:13]);
  assign rd            = ir_q[12:11];
  assign rs            = ir_q[10:9];
  assign imm           = ir_q[7:0];
  assign unused_ir_bit = ir_q[8];

  // Operand selection. The register file is only written at the WB->IDLE
  // edge, so these still show the pre-write values during WB and can be
  // reused there to derive the overflow flag (also covers rd == rs).
  logic       use_imm;
  logic [7:0] op_a, op_b;

  assign use_imm = op inside {OP_LDI, OP_ADDI, OP_SUBI};
  assign op_a    = (op == OP_LDI) ? 8'h00 : rf_q[rd];
  assign op_b    = use_imm ? imm : rf_q[rs];

  // Drive the ALU only in EXEC; everything is zero in the other states.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_add_sub  = 1'b0;
    alu_set_low  = 1'b0;
    alu_set_high = 1'b0;
    alu_a        = 8'h00;
    alu_b        = 8'h00;
    if (state_q == S_EXEC) begin
      alu_a        = op_a;
      alu_b        = op_b;
      alu_add_sub  = op inside {OP_SUB, OP_SUBI};
      alu_set_low  = (op == OP_SETLO);
      alu_set_high = (op == OP_SETHI);
    end
  end

  // Next-state logic: accept in IDLE, sample the ALU in EXEC, retire in WB.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Signed-overflow flag for the value retiring in WB.
  logic v_new;
  always_comb begin
    v_new = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: v_new = (op_a[7] == op_b[7]) && (res_q[7] != op_a[7]);
      OP_SUB, OP_SUBI: v_new = (op_a[7] != op_b[7]) && (res_q[7] != op_a[7]);
      default:         v_new = 1'b0;
    endcase
  end

  logic wb_en;
  assign wb_en = (state_q == S_WB) && (op != OP_NOP);

  // State, instruction and ALU-result registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
      res_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
    end
  end

  // Register file, result and flags are written once per retiring op.
  // NOTE: the register file is reset like ordinary flops; it is only four
  // bytes and software relies on it reading zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'h00;
      result_q <= 8'h00;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (wb_en) begin
      rf_q[rd] <= res_q;
      result_q <= res_q;
      z_q      <= (res_q == 8'h00);
      n_q      <= res_q[7];
      v_q      <= v_new;
    end
  end

  // done pulses for one cycle after every WB, NOP included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= (state_q == S_WB);
  end

  assign instr_ready = (state_q == S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign flag_z      = z_q;
  assign flag_n      = n_q;
  assign flag_v      = v_q;
  assign dbg_data    = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, runs directed and random
// instructions and compares against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_add_sub, alu_set_low, alu_set_high;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic        done;
  logic [7:0]  result;
  logic        flag_z, flag_n, flag_v;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_rf [4];
  logic [7:0] m_result;
  logic       m_z, m_n, m_v;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_add_sub  (alu_add_sub),
    .alu_set_low  (alu_set_low),
    .alu_set_high (alu_set_high),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .done         (done),
    .result       (result),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_v       (flag_v),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // Combinational ALU that lives outside the block
  always_comb begin
    if (alu_set_low)       alu_result = {alu_a[7:4], alu_b[3:0]};
    else if (alu_set_high) alu_result = {alu_b[3:0], alu_a[3:0]};
    else if (alu_add_sub)  alu_result = alu_a - alu_b;
    else                   alu_result = alu_a + alu_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction

  function automatic int to_s(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  function automatic bit is_imm_op(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_result = 8'h00;
    {m_z, m_n, m_v} = 3'b000;
  endtask

  // Architectural effect of one instruction, from plain signed arithmetic
  task automatic model_apply(input logic [15:0] ins);
    logic [2:0] op;
    logic [7:0] a, b, r;
    int         s;
    logic       v;
    op = ins[15:13];
    a  = m_rf[ins[12:11]];
    b  = is_imm_op(op) ? ins[7:0] : m_rf[ins[10:9]];
    v  = 1'b0;
    r  = 8'h00;
    case (op)
      3'd0, 3'd5: begin s = to_s(a) + to_s(b); r = 8'(s); v = (s > 127) || (s < -128); end
      3'd1, 3'd6: begin s = to_s(a) - to_s(b); r = 8'(s); v = (s > 127) || (s < -128); end
      3'd2:       r = (a & 8'hF0) | (b & 8'h0F);
      3'd3:       r = 8'((int'(b) % 16) * 16 + int'(a) % 16);
      3'd4:       r = b;
      default:    return;
    endcase
    m_rf[ins[12:11]] = r;
    m_result = r;
    m_z = (r == 8'h00);
    m_n = (r >= 8'h80);
    m_v = v;
  endtask

  task automatic check_state(input string tag);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("%s rf[%0d]", tag, r), dbg_data, m_rf[r]);
    end
    check({tag, " flags"}, {flag_z, flag_n, flag_v}, {m_z, m_n, m_v});
    check({tag, " result"}, result, m_result);
  endtask

  // Issue one instruction and follow it through EXEC, WB and retirement
  task automatic exec_instr(input string tag, input logic [15:0] ins);
    logic [2:0] op;
    logic [7:0] exp_a, exp_b;
    logic [2:0] exp_ctl;
    op      = ins[15:13];
    exp_a   = (op == 3'd4) ? 8'h00 : m_rf[ins[12:11]];
    exp_b   = is_imm_op(op) ? ins[7:0] : m_rf[ins[10:9]];
    exp_ctl = {(op == 3'd1) || (op == 3'd6), op == 3'd2, op == 3'd3};
    @(negedge clk);
    check({tag, " idle done"}, done, 1'b0);
    check({tag, " idle ready"}, instr_ready, 1'b1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    @(negedge clk);
    check({tag, " exec ready"}, instr_ready, 1'b0);
    check({tag, " exec ctl"}, {alu_add_sub, alu_set_low, alu_set_high}, exp_ctl);
    check({tag, " exec a"}, alu_a, exp_a);
    if (op != 3'd7) check({tag, " exec b"}, alu_b, exp_b);
    check({tag, " exec done"}, done, 1'b0);
    @(negedge clk);
    check({tag, " wb done"}, done, 1'b0);
    check({tag, " wb ctl"}, {alu_add_sub, alu_set_low, alu_set_high, alu_a, alu_b}, 19'h0);
    model_apply(ins);
    @(negedge clk);
    check({tag, " retire done"}, done, 1'b1);
    check({tag, " retire ready"}, instr_ready, 1'b1);
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] acc_q[$];
    logic [15:0] ins;

    // Reset values, checked while reset is held
    reset_n     = 1'b0;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    dbg_sel     = 2'd0;
    model_reset();
    #12;
    check("rst ready", instr_ready, 1'b1);
    check("rst alu", {alu_add_sub, alu_set_low, alu_set_high, alu_a, alu_b}, 19'h0);
    check("rst done", done, 1'b0);
    check_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // Basic subtract
    exec_instr("ldi r0", mk(3'd4, 2'd0, 2'd0, 8'h05));
    exec_instr("ldi r1", mk(3'd4, 2'd1, 2'd0, 8'h03));
    exec_instr("sub r0r1", mk(3'd1, 2'd0, 2'd1, 8'h00));
    dbg_sel = 2'd0;
    #1;
    check("tp1 r0", dbg_data, 8'h02);
    check("tp1 flags", {flag_z, flag_n, flag_v}, 3'b000);

    // Overflow boundaries
    exec_instr("ldi r2", mk(3'd4, 2'd2, 2'd0, 8'h7F));
    exec_instr("addi r2", mk(3'd5, 2'd2, 2'd0, 8'h01));
    check("tp2 add res", result, 8'h80);
    check("tp2 add flags", {flag_z, flag_n, flag_v}, 3'b011);
    exec_instr("subi r2", mk(3'd6, 2'd2, 2'd0, 8'h01));
    check("tp2 sub res", result, 8'h7F);
    check("tp2 sub flags", {flag_z, flag_n, flag_v}, 3'b001);
    exec_instr("ldi r3", mk(3'd4, 2'd3, 2'd0, 8'h00));
    check("tp2 ldi flags", {flag_z, flag_n, flag_v}, 3'b100);

    // Nibble ops
    exec_instr("ldi r0 a5", mk(3'd4, 2'd0, 2'd0, 8'hA5));
    exec_instr("ldi r1 3c", mk(3'd4, 2'd1, 2'd0, 8'h3C));
    exec_instr("setlo", mk(3'd2, 2'd0, 2'd1, 8'h00));
    check("tp3 setlo", result, 8'hAC);
    exec_instr("ldi r0 a5b", mk(3'd4, 2'd0, 2'd0, 8'hA5));
    exec_instr("sethi", mk(3'd3, 2'd0, 2'd1, 8'h00));
    check("tp3 sethi", result, 8'hC5);

    // rd == rs and NOP
    exec_instr("add r1r1", mk(3'd0, 2'd1, 2'd1, 8'h00));
    exec_instr("nop", mk(3'd7, 2'd2, 2'd3, 8'hFF));

    // Random instructions
    for (int k = 0; k < 30; k++) begin
      ins = 16'($urandom);
      exec_instr($sformatf("rand%0d", k), ins);
    end

    // Continuous instr_valid: accepts only every third cycle
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("burst%0d ready", i), instr_ready, (i % 3 == 0));
      check($sformatf("burst%0d done", i), done, (i % 3 == 0) && (i >= 3));
      ins         = (i == 3) ? mk(3'd7, 2'd0, 2'd1, 8'h00) : 16'($urandom);
      instr       = ins;
      instr_valid = (i < 10);
      if (i < 10 && i % 3 == 0) acc_q.push_back(ins);
    end
    instr_valid = 1'b0;
    foreach (acc_q[j]) model_apply(acc_q[j]);
    check_state("burst");

    // Reset during EXEC abandons the instruction
    exec_instr("ldi r0 10", mk(3'd4, 2'd0, 2'd0, 8'h10));
    @(negedge clk);
    instr       = mk(3'd0, 2'd0, 2'd0, 8'h00);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("mid exec a", alu_a, 8'h10);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid rst ready", instr_ready, 1'b1);
    check("mid rst alu", {alu_add_sub, alu_set_low, alu_set_high, alu_a, alu_b}, 19'h0);
    check("mid rst done", done, 1'b0);
    check_state("mid rst");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post rst done%0d", i), done, 1'b0);
      check($sformatf("post rst ready%0d", i), instr_ready, 1'b1);
    end
    exec_instr("post rst ldi", mk(3'd4, 2'd1, 2'd0, 8'h42));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Instruction-driven controller for the 8-bit signed ALU (add_sub / set_low / set_high datapath). It accepts 16-bit instructions over a valid/ready handshake and holds a 4×8 register file. It drives the ALU control and operand inputs for one cycle per instruction and writes the ALU result back with Z/N/V flags. It sits between the instruction source (switches, ROM or test sequencer) and the existing combinational ALU, which is instantiated outside this block.

## Interface
- Parameters: none; data width is fixed at 8 bits and instruction width at 16 bits.
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr  in  16  instruction word: op[15:13], rd[12:11], rs[10:9], [8] unused, imm[7:0]
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  block can accept; high only in IDLE
- alu_add_sub  out  1  to ALU add_sub (1 = subtract)
- alu_set_low  out  1  to ALU set_low
- alu_set_high  out  1  to ALU set_high
- alu_a  out  8  to ALU operanda
- alu_b  out  8  to ALU operandb
- alu_result  in  8  from ALU result (combinational)
- done  out  1  one-cycle pulse when an instruction retires
- result  out  8  last written value; held until the next write
- flag_z, flag_n, flag_v  out  1 each  zero, negative and signed-overflow flags
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  combinational read of rf[dbg_sel]; reflects writes the cycle after the write edge

## Operation
- Opcodes:
  - 000 ADD: rd = rd + rs
  - 001 SUB: rd = rd − rs
  - 010 SETLO: rd = {rd[7:4], rs[3:0]}
  - 011 SETHI: rd = {rs[3:0], rd[3:0]}
  - 100 LDI: rd = imm
  - 101 ADDI: rd = rd + imm
  - 110 SUBI: rd = rd − imm
  - 111 NOP: no write
- ALU drive in EXEC:
  - alu_a = rf[rd] for all ops except LDI; for LDI, alu_a = 0.
  - alu_b = rf[rs] for ADD, SUB, SETLO, SETHI; alu_b = imm for LDI, ADDI, SUBI.
  - alu_add_sub = 1 for SUB and SUBI; alu_set_low = 1 for SETLO; alu_set_high = 1 for SETHI.
  - LDI is executed as 0 + imm.
- Outside EXEC, all ALU controls and operands are 0.
- Arithmetic wraps modulo 2^8 (two's complement). No saturation.
- Overflow rules:
  - ADD/ADDI: V = (a[7]==b[7]) && (r[7]!=a[7]).
  - SUB/SUBI: V = (a[7]!=b[7]) && (r[7]!=a[7]).
- Flag updates:
  - Every writing op updates Z = (r==0) and N = r[7].
  - V is updated by ADD/SUB/ADDI/SUBI and cleared by SETLO/SETHI/LDI.
  - NOP leaves all flags, result and the register file unchanged, but still pulses done.
- rd == rs is legal; both operands read the pre-write value.
- FSM states and transitions:
  - IDLE → EXEC on instr_valid && instr_ready; instr is captured into ir.
  - EXEC → WB unconditionally; alu_result is captured into res_q.
  - WB → IDLE unconditionally; rf[rd], result and flags are written and done is set.
- instr_valid is ignored outside IDLE. instr may change freely once accepted.

## Timing
- Reset values (asynchronous, immediate): state = IDLE, rf[0..3] = 0, ir = 0, res_q = 0, result = 0, flags = 0, done = 0. instr_ready = 1 and all ALU outputs = 0 while reset_n = 0 and after release.
- Cycle numbering, with accept at edge E0:
  - Cycle after E0: EXEC; ALU outputs valid; instr_ready = 0.
  - Edge E1: alu_result is sampled into res_q.
  - Cycle after E1: WB.
  - Edge E2: rf, result and flags update; done goes high.
  - Cycle after E2: IDLE with done = 1 and instr_ready = 1.
  - done clears at E3 unless a write pulse is again due, which cannot happen at E3.
- Latency: accept to done-high is 2 edges. Maximum throughput is one instruction per 3 cycles under continuous instr_valid.
- A new instruction accepted at E3 reads the register file after the E2 write; no hazard exists.
- Reset asserted in EXEC or WB: the instruction is abandoned with no rf, flag or result write and no done pulse. The block restarts in IDLE.

## Test plan
- Reset, then LDI r0,0x05; LDI r1,0x03; SUB r0,r1 → r0 = 0x02, Z = 0, N = 0, V = 0, one done per instruction, dbg_data(0) = 0x02.
- LDI r2,0x7F; ADDI r2,0x01 → r2 = 0x80, N = 1, V = 1. Then SUBI r2,0x01 → 0x7F, V = 1, N = 0. Then LDI r3,0x00 → Z = 1, V = 0.
- r0 = 0xA5, r1 = 0x3C: SETLO r0,r1 → 0xAC. Reload r0 = 0xA5, then SETHI r0,r1 → 0xC5. During each EXEC cycle, check that exactly the correct ALU control bit is high.
- Hold instr_valid = 1 for 10 cycles with changing instr → accepts occur only on cycles where instr_ready = 1 (every 3rd cycle). done pulses exactly 1 cycle per accept. NOP produces done with no state change.
- Assert reset_n low during the EXEC cycle of ADD r0,r0 with r0 = 0x10 → no done, r0 = 0, all flags 0, instr_ready = 1. The next LDI executes normally.
